conv_host_streamer: RTL and testbench
=====================================

Name: conv_host_streamer

Overview:
Host-side counterpart of the convolution accelerator's bus interface. It streams kernel words, then feature words, from a synchronous source memory onto the accelerator input bus using a valid/ready handshake. It captures every output beat the accelerator drives back and writes it to a result memory. It sits between the system memories and the accelerator, replacing the testbench driver in the integrated design.

Parameters:
FEATURE_MAP_WIDTH, 128, feature map width in pixels (power of 2)
FEATURE_MAP_HEIGHT, 128, feature map height in pixels (power of 2)
BUS_WIDTH, 48, input/output bus data width in bits
KERNEL_BEATS, 144, kernel beats per run (9 addresses x 16 groups)
FEATURE_BEATS, 6, feature beats per output position; also output beats per position
SRC_ADDR_WIDTH, 18, source memory address width

Ports:
clk  in  1  clock
arst_n_in  in  1  asynchronous reset, active low
start  in  1  launch one run (sampled in IDLE only)
conv_stride_mode  in  2  0: stride 1, 1: stride 2, 2: stride 4, 3: illegal
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the run completes
mem_re  out  1  source memory read enable
mem_addr  out  SRC_ADDR_WIDTH  source read address
mem_rdata  in  BUS_WIDTH  source data, valid 1 cycle after mem_re
bus_valid  out  1  input beat offered to accelerator
bus_ready  in  1  accelerator accepts beat
bus_data  out  BUS_WIDTH  input beat payload
driving_busses  in  1  accelerator owns the shared bus
output_valid  in  1  accelerator output beat valid
output_x  in  $clog2(FEATURE_MAP_WIDTH)  output position x
output_y  in  $clog2(FEATURE_MAP_HEIGHT)  output position y
output_data  in  BUS_WIDTH  output beat payload
res_we  out  1  result memory write enable
res_addr  out  $clog2(W)+$clog2(H)+3  result address {output_y, output_x, beat[2:0]}
res_wdata  out  BUS_WIDTH  result data
stall_cycles  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0. State IDLE, counters and FIFO cleared. An asserted reset mid-run aborts the run; no done pulse is produced.
- Run size: at start, latch mode and compute POS = (W>>mode)*(H>>mode). Then TOTAL_IN = KERNEL_BEATS + POS*FEATURE_BEATS and TOTAL_OUT = POS*FEATURE_BEATS.
- Mode 3: start is ignored and the block stays IDLE. start while busy is ignored.
- States and transitions:
  - IDLE -> FETCH on a legal start.
  - FETCH: source reads issue and beats are sent until all TOTAL_IN beats are accepted, then -> DRAIN. The kernel/feature split is by beat index only; the source holds kernels at addresses 0..KERNEL_BEATS-1 and features from there on.
  - DRAIN: waits until TOTAL_OUT output beats are captured, then -> DONE.
  - DONE: one cycle, done=1, then -> IDLE.
- Prefetch:
  - mem_addr = read counter, 0..TOTAL_IN-1, incrementing on each mem_re.
  - Read data enters a 2-entry FIFO one cycle later.
  - mem_re=1 only when (FIFO occupancy + reads in flight) < 2 and the read counter < TOTAL_IN.
- Handshake:
  - bus_valid = FIFO non-empty AND !driving_busses.
  - bus_data = FIFO head, held stable until accepted.
  - A beat is accepted when bus_valid && bus_ready; the FIFO pops in the same cycle.
  - Once bus_valid is raised, it stays high until acceptance unless driving_busses rises. In that case bus_valid drops, the data is kept, and the same beat is re-offered.
- Output capture:
  - On output_valid=1: res_we=1 with res_addr={output_y, output_x, obeat}, where obeat counts 0..5 and wraps per position.
  - res_wdata=output_data. Registered, so the write appears 1 cycle after output_valid.
  - Capture is active in FETCH and DRAIN. output_valid in IDLE/DONE is ignored.
- Simultaneous accept and capture in one cycle: both are processed.
- Simultaneous FIFO push and pop: occupancy is unchanged.
- The FIFO never overflows; push when full is an assertion failure.

Optional Feature:
CONV_HOST_PERF_CNT_EN
- Defined: stall_cycles counts cycles in FETCH with bus_valid && !bus_ready. It clears on an accepted start, saturates at 2^32-1, and holds after done.
- Undefined: stall_cycles is tied to 0 and no counter logic is generated.

Decomposition:
- Package conv_host_pkg: state enum (IDLE, FETCH, DRAIN, DONE), mode-to-shift constant, and a function computing POS from mode and map sizes.
- Sub-module conv_stream_fifo2: 2-entry FIFO, BUS_WIDTH wide, with push/pop/full/empty/count.

Test Plan:
- W=H=8, mode 0, bus_ready always 1, accelerator model echoes beats -> exactly 528 accepted beats, mem_addr spans 0..527, 384 result writes, done pulses once, busy then falls.
- W=H=8, mode 1, bus_ready toggling 1/0 every cycle -> 240 beats in address order with no duplicates or drops; with CONV_HOST_PERF_CNT_EN, stall_cycles equals the count of ready-low cycles while valid.
- driving_busses held high 6 cycles in the middle of a stalled beat -> bus_valid is 0 for those 6 cycles, the same bus_data is re-offered afterwards, and 6 result writes land at {y, x, 0..5}.
- start with mode 3 -> busy stays 0, no mem_re, no done.
- Reset asserted at beat 100 of a mode 0 run -> all outputs 0 immediately; a fresh start restarts mem_addr at 0 and the run completes normally.
- output_valid pulses in IDLE -> no res_we.

Source files
------------

// File: rtl/conv_host_pkg.sv
// Shared state encoding and run-size helpers for the convolution host streamer.
// Pure definitions: no latency, no backpressure.
package conv_host_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_ILLEGAL = 2'd3;

   // Map-dimension right shift per stride mode, two bits per mode; mode 3 never used.
   localparam logic [7:0] MODE_SHIFT = {2'd0, 2'd2, 2'd1, 2'd0};

   function automatic logic [1:0] mode_shift(input logic [1:0] mode);
      return MODE_SHIFT[{mode, 1'b0} +: 2];
   endfunction

   function automatic logic [31:0] calc_pos(input logic [1:0]  mode,
                                            input logic [31:0] map_w,
                                            input logic [31:0] map_h);
      logic [1:0] w_sh;
      w_sh = mode_shift(mode);
      return (map_w >> w_sh) * (map_h >> w_sh);
   endfunction

endpackage

// File: rtl/conv_stream_fifo2.sv
// Two-entry FIFO between the source memory read port and the accelerator input bus.
// Head is combinational from storage; push and pop in one cycle leave the count unchanged.
module conv_stream_fifo2 #(
   parameter int WIDTH = 48
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_dat,
   output logic             o_full,
   output logic             o_empty,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_pop;

   assign w_pop = i_pop && (r_count != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_dat = r_mem[r_rd_ptr];
   assign o_full     = (r_count == 2'd2);
   assign o_empty    = (r_count == 2'd0);
   assign o_count    = r_count;

   // The read-issue throttle upstream must make a push into a full FIFO impossible.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && (r_count == 2'd2)));

endmodule

// File: rtl/conv_host_streamer.sv
// Streams kernel then feature words from source memory to the accelerator and captures its output beats.
// Optional stall counter under CONV_HOST_PERF_CNT_EN; bus_data held until accepted, reads throttled to FIFO space.
module conv_host_streamer
   import conv_host_pkg::*;
#(
   parameter int FEATURE_MAP_WIDTH  = 128,
   parameter int FEATURE_MAP_HEIGHT = 128,
   parameter int BUS_WIDTH          = 48,
   parameter int KERNEL_BEATS       = 144,
   parameter int FEATURE_BEATS      = 6,
   parameter int SRC_ADDR_WIDTH     = 18
) (
   input  logic                                  clk,
   input  logic                                  arst_n_in,
   input  logic                                  start,
   input  logic [1:0]                            conv_stride_mode,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  mem_re,
   output logic [SRC_ADDR_WIDTH-1:0]             mem_addr,
   input  logic [BUS_WIDTH-1:0]                  mem_rdata,
   output logic                                  bus_valid,
   input  logic                                  bus_ready,
   output logic [BUS_WIDTH-1:0]                  bus_data,
   input  logic                                  driving_busses,
   input  logic                                  output_valid,
   input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
   input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
   input  logic [BUS_WIDTH-1:0]                  output_data,
   output logic                                  res_we,
   output logic [$clog2(FEATURE_MAP_WIDTH)+$clog2(FEATURE_MAP_HEIGHT)+2:0] res_addr,
   output logic [BUS_WIDTH-1:0]                  res_wdata,
   output logic [31:0]                           stall_cycles
);

   localparam int XW     = $clog2(FEATURE_MAP_WIDTH);
   localparam int YW     = $clog2(FEATURE_MAP_HEIGHT);
   localparam int RES_AW = XW + YW + 3;

   localparam logic [SRC_ADDR_WIDTH-1:0] ADDR_ONE   = 1;
   localparam logic [2:0]                OBEAT_LAST = 3'(FEATURE_BEATS - 1);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      w_busy;
   logic                      w_done;

   logic [SRC_ADDR_WIDTH-1:0] r_rd_cnt;
   logic [31:0]               r_acc_cnt;
   logic [31:0]               r_out_cnt;
   logic [31:0]               r_total_in;
   logic [31:0]               r_total_out;
   logic                      r_inflight;
   logic [2:0]                r_obeat;

   logic                      r_res_we;
   logic [RES_AW-1:0]         r_res_addr;
   logic [BUS_WIDTH-1:0]      r_res_wdata;

   logic [31:0]               w_pos;
   logic                      w_start_ok;
   logic                      w_accept;
   logic                      w_capture;
   logic                      w_mem_re;
   logic                      w_bus_valid;
   logic [1:0]                w_occ;

   logic [BUS_WIDTH-1:0]      w_fifo_head;
   logic                      w_fifo_full;
   logic                      w_fifo_empty;
   logic [1:0]                w_fifo_count;

   assign w_pos      = calc_pos(conv_stride_mode, FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT);
   assign w_start_ok = (r_state == IDLE) && start && (conv_stride_mode != MODE_ILLEGAL);

   // Reads already in flight count against FIFO space so a push never finds it full.
   assign w_occ       = w_fifo_count + {1'b0, r_inflight};
   assign w_mem_re    = (r_state == FETCH) && !w_fifo_full && (w_occ < 2'd2)
                        && (32'(r_rd_cnt) < r_total_in);
   assign w_bus_valid = !w_fifo_empty && !driving_busses;
   assign w_accept    = w_bus_valid && bus_ready;
   assign w_capture   = output_valid && ((r_state == FETCH) || (r_state == DRAIN));

   conv_stream_fifo2 #(
      .WIDTH      (BUS_WIDTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (arst_n_in),
      .i_push     (r_inflight),
      .i_push_dat (mem_rdata),
      .i_pop      (w_accept),
      .o_head_dat (w_fifo_head),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty),
      .o_count    (w_fifo_count)
   );

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (w_start_ok) begin
               w_state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (w_accept && (r_acc_cnt == r_total_in - 32'd1)) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (r_out_cnt >= r_total_out) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_busy      = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_rd_cnt    <= '0;
         r_acc_cnt   <= '0;
         r_out_cnt   <= '0;
         r_total_in  <= '0;
         r_total_out <= '0;
         r_inflight  <= 1'b0;
         r_obeat     <= '0;
      end else begin
         r_inflight <= w_mem_re;
         if (w_start_ok) begin
            r_total_out <= w_pos * 32'(FEATURE_BEATS);
            r_total_in  <= 32'(KERNEL_BEATS) + w_pos * 32'(FEATURE_BEATS);
            r_rd_cnt    <= '0;
            r_acc_cnt   <= '0;
            r_out_cnt   <= '0;
            r_obeat     <= '0;
         end else begin
            if (w_mem_re) begin
               r_rd_cnt <= r_rd_cnt + ADDR_ONE;
            end
            if (w_accept) begin
               r_acc_cnt <= r_acc_cnt + 32'd1;
            end
            if (w_capture) begin
               r_out_cnt <= r_out_cnt + 32'd1;
               r_obeat   <= (r_obeat == OBEAT_LAST) ? 3'd0 : r_obeat + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_res_we    <= 1'b0;
         r_res_addr  <= '0;
         r_res_wdata <= '0;
      end else begin
         r_res_we <= w_capture;
         if (w_capture) begin
            r_res_addr  <= {output_y, output_x, r_obeat};
            r_res_wdata <= output_data;
         end
      end
   end

`ifdef CONV_HOST_PERF_CNT_EN
   logic [31:0] r_stall;

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_stall <= '0;
      end else if (w_start_ok) begin
         r_stall <= '0;
      end else if ((r_state == FETCH) && w_bus_valid && !bus_ready && (r_stall != '1)) begin
         r_stall <= r_stall + 32'd1;
      end
   end

   assign stall_cycles = r_stall;
`else
   assign stall_cycles = 32'd0;
`endif

   assign busy      = w_busy;
   assign done      = w_done;
   assign mem_re    = w_mem_re;
   assign mem_addr  = r_rd_cnt;
   assign bus_valid = w_bus_valid;
   assign bus_data  = w_fifo_head;
   assign res_we    = r_res_we;
   assign res_addr  = r_res_addr;
   assign res_wdata = r_res_wdata;

endmodule

// File: tb/tb_conv_host_streamer.sv
// Randomized bench for conv_host_streamer on an 8x8 map with a source memory and echoing accelerator model.
// Expected beats, addresses and result writes come from the run-size rules, not from the design.
module tb_conv_host_streamer;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int BW = 48;
   localparam int KB = 144;
   localparam int FB = 6;
   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          arst_n_in;
   logic          start;
   logic [1:0]    conv_stride_mode;
   logic          busy;
   logic          done;
   logic          mem_re;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_rdata;
   logic          bus_valid;
   logic          bus_ready;
   logic [BW-1:0] bus_data;
   logic          driving_busses;
   logic          output_valid;
   logic [2:0]    output_x;
   logic [2:0]    output_y;
   logic [BW-1:0] output_data;
   logic          res_we;
   logic [8:0]    res_addr;
   logic [BW-1:0] res_wdata;
   logic [31:0]   stall_cycles;

   int total = 0;
   int bad   = 0;
   logic [BW-1:0] src_mem [0:1023];

   always #5 clk = ~clk;

   conv_host_streamer #(
      .FEATURE_MAP_WIDTH  (W),
      .FEATURE_MAP_HEIGHT (H),
      .BUS_WIDTH          (BW),
      .KERNEL_BEATS       (KB),
      .FEATURE_BEATS      (FB),
      .SRC_ADDR_WIDTH     (AW)
   ) dut (
      .clk              (clk),
      .arst_n_in        (arst_n_in),
      .start            (start),
      .conv_stride_mode (conv_stride_mode),
      .busy             (busy),
      .done             (done),
      .mem_re           (mem_re),
      .mem_addr         (mem_addr),
      .mem_rdata        (mem_rdata),
      .bus_valid        (bus_valid),
      .bus_ready        (bus_ready),
      .bus_data         (bus_data),
      .driving_busses   (driving_busses),
      .output_valid     (output_valid),
      .output_x         (output_x),
      .output_y         (output_y),
      .output_data      (output_data),
      .res_we           (res_we),
      .res_addr         (res_addr),
      .res_wdata        (res_wdata),
      .stall_cycles     (stall_cycles)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero();
      chk("rst_ctl",   64'({busy, done, mem_re, bus_valid, res_we}), 64'(0));
      chk("rst_addr",  64'({mem_addr, res_addr}), 64'(0));
      chk("rst_bdat",  64'(bus_data), 64'(0));
      chk("rst_wdat",  64'(res_wdata), 64'(0));
      chk("rst_stall", 64'(stall_cycles), 64'(0));
   endtask

   task automatic run_test(input logic [1:0] mode, input int rpol, input bit do_drive, input int abort_at);
      int xs, pos, tin, tout, p;
      int acc, nre, nwr, ndone, max_addr, out_idx, stall_exp, drive_left, post_cnt, rd_addr;
      bit rd_pend, stalled, done_seen, drive_used, drive_chk;
      logic [BW-1:0] prev_dat, drive_dat;
      logic [BW-1:0] echo_q[$];
      int            wa_q[$];
      logic [BW-1:0] wd_q[$];
      xs = W >> mode;
      pos = xs * (H >> mode);
      tout = pos * FB;
      tin = KB + tout;
      acc = 0; nre = 0; nwr = 0; ndone = 0; max_addr = -1; out_idx = 0;
      stall_exp = 0; drive_left = 0; post_cnt = 0; rd_addr = 0;
      rd_pend = 0; stalled = 0; done_seen = 0; drive_used = 0; drive_chk = 0;
      prev_dat = '0; drive_dat = '0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         start = (cyc == 0);
         conv_stride_mode = mode;
         mem_rdata = rd_pend ? src_mem[rd_addr] : 48'({$urandom(), $urandom()});
         case (rpol)
            0:       bus_ready = 1'b1;
            1:       bus_ready = (cyc % 2 == 0);
            default: bus_ready = ($urandom_range(0, 3) != 0);
         endcase
         driving_busses = (drive_left > 0);
         if (drive_left > 0) drive_left--;
         if (echo_q.size() > 0 && (driving_busses || acc == tin)) begin
            p = out_idx / FB;
            output_valid = 1'b1;
            output_x = 3'(p % xs);
            output_y = 3'(p / xs);
            output_data = echo_q.pop_front();
            wa_q.push_back((p / xs) * 64 + (p % xs) * 8 + out_idx % FB);
            wd_q.push_back(output_data);
            out_idx++;
         end else begin
            output_valid = 1'b0;
            output_x = 3'($urandom());
            output_y = 3'($urandom());
            output_data = 48'({$urandom(), $urandom()});
         end
         #1;
         if (cyc == 1) chk("busy_start", 64'(busy), 64'(1));
         if (driving_busses) begin
            chk("drv_valid", 64'(bus_valid), 64'(0));
         end else if (drive_chk) begin
            chk("drv_revld", 64'(bus_valid), 64'(1));
            chk("drv_redat", 64'(bus_data), 64'(drive_dat));
            drive_chk = 0;
         end else if (stalled) begin
            chk("hold_vld", 64'(bus_valid), 64'(1));
            chk("hold_dat", 64'(bus_data), 64'(prev_dat));
         end
         if (bus_valid && bus_ready) begin
            if (acc < tin) begin
               chk("beat", 64'(bus_data), 64'(src_mem[acc]));
               if (acc >= KB) echo_q.push_back(src_mem[acc]);
            end else begin
               chk("extra_beat", 64'(acc), 64'(tin));
            end
            acc++;
         end
         rd_pend = mem_re;
         if (mem_re) begin
            chk("rd_addr", 64'(mem_addr), 64'(nre));
            rd_addr = int'(mem_addr) & 1023;
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            nre++;
         end
         if (bus_valid && !bus_ready) stall_exp++;
         if (res_we) begin
            nwr++;
            if (wa_q.size() == 0) begin
               chk("wr_extra", 64'(res_we), 64'(0));
            end else begin
               chk("wr_addr", 64'(res_addr), 64'(wa_q.pop_front()));
               chk("wr_dat", 64'(res_wdata), 64'(wd_q.pop_front()));
            end
         end
         if (done) begin
            ndone++;
            if (!done_seen) chk("busy_at_done", 64'(busy), 64'(1));
            done_seen = 1;
         end
         stalled = bus_valid && !bus_ready;
         prev_dat = bus_data;
         if (do_drive && !drive_used && stalled && echo_q.size() >= FB) begin
            drive_left = FB;
            drive_used = 1;
            drive_dat = bus_data;
            drive_chk = 1;
         end
         if (abort_at >= 0 && acc == abort_at) begin
            arst_n_in = 1'b0;
            start = 1'b0;
            output_valid = 1'b0;
            driving_busses = 1'b0;
            #1;
            chk_zero();
            return;
         end
         if (done_seen) post_cnt++;
         if (post_cnt > 3) break;
      end
      start = 1'b0;
      output_valid = 1'b0;
      chk("done_seen", 64'(done_seen), 64'(1));
      chk("n_acc", 64'(acc), 64'(tin));
      chk("n_re", 64'(nre), 64'(tin));
      chk("max_addr", 64'(max_addr), 64'(tin - 1));
      chk("n_wr", 64'(nwr), 64'(tout));
      chk("n_done", 64'(ndone), 64'(1));
      chk("busy_end", 64'(busy), 64'(0));
      chk("wr_left", 64'(wa_q.size()), 64'(0));
`ifdef CONV_HOST_PERF_CNT_EN
      chk("stall", 64'(stall_cycles), 64'(stall_exp));
`else
      chk("stall", 64'(stall_cycles), 64'(0));
`endif
      if (do_drive) chk("drv_fired", 64'(drive_used), 64'(1));
   endtask

   initial begin
      int n_re, n_done, n_busy;
      arst_n_in = 1'b0;
      start = 1'b0;
      conv_stride_mode = 2'd0;
      mem_rdata = '0;
      bus_ready = 1'b0;
      driving_busses = 1'b0;
      output_valid = 1'b0;
      output_x = '0;
      output_y = '0;
      output_data = '0;
      for (int i = 0; i < 1024; i++) src_mem[i] = 48'({$urandom(), $urandom()});
      repeat (3) @(negedge clk);
      #1;
      chk_zero();
      @(negedge clk);
      arst_n_in = 1'b1;

      // output_valid while idle must never reach the result memory
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         output_valid = (i < 8);
         output_x = 3'($urandom());
         output_y = 3'($urandom());
         output_data = 48'({$urandom(), $urandom()});
         #1;
         chk("idle_we", 64'(res_we), 64'(0));
      end
      output_valid = 1'b0;

      // illegal stride mode
      @(negedge clk);
      start = 1'b1;
      conv_stride_mode = 2'd3;
      n_re = 0; n_done = 0; n_busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (mem_re) n_re++;
         if (done) n_done++;
         if (busy) n_busy++;
      end
      chk("m3_re", 64'(n_re), 64'(0));
      chk("m3_done", 64'(n_done), 64'(0));
      chk("m3_busy", 64'(n_busy), 64'(0));

      run_test(2'd0, 0, 1'b0, -1);
      run_test(2'd1, 1, 1'b1, -1);
      run_test(2'd2, 2, 1'b0, -1);
      run_test(2'd0, 2, 1'b0, 100);
      @(negedge clk);
      arst_n_in = 1'b1;
      repeat (2) @(negedge clk);
      run_test(2'd0, 1, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
